multiword_comparator: RTL
=========================

MULTIWORD_COMPARATOR -- requirements
Module: multiword_comparator

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand width in bits.
REQ-002 SHALL have parameter CHUNK_W, default 4: bits compared per cycle; DATA_W SHALL be an integer multiple of CHUNK_W; NCHUNK = DATA_W/CHUNK_W.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operands and cascade bits present.
REQ-006 SHALL have port in_ready, output, 1: block accepts operands.
REQ-007 SHALL have ports a and b, input, DATA_W each: operands.
REQ-008 SHALL have ports eq_in, gt_in and lt_in, input, 1 each: cascade from a less-significant stage.
REQ-009 SHALL have port out_valid, output, 1: result present.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have ports eq_out, gt_out and lt_out, output, 1 each: registered result.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 exactly in IDLE, and out_valid SHALL be 1 exactly in DONE.
REQ-014 IDLE: on in_valid&in_ready, SHALL capture a, b and the cascade bits, set chunk index to NCHUNK-1 and go to BUSY.
REQ-015 BUSY: each cycle SHALL compare one CHUNK_W slice, MSB chunk first, then decrement the index.
REQ-016 BUSY early exit: the first unequal chunk SHALL load gt_out/lt_out per that chunk, clear eq_out and go to DONE.
REQ-017 BUSY all-equal: if chunk 0 is equal, SHALL load eq_out=eq_in&1, gt_out=gt_in and lt_out=lt_in from the captured cascade bits, verbatim, and go to DONE.
REQ-018 Latency: if the j-th processed chunk (1-based) decides the result, out_valid SHALL rise j cycles after the accept edge; all-equal operands take NCHUNK cycles.
REQ-019 DONE: result outputs SHALL be held stable while out_ready=0; on out_valid&out_ready SHALL return to IDLE, so in_ready is 1 the next cycle.
REQ-020 in_valid SHALL be ignored outside IDLE.
REQ-021 Throughput SHALL be no better than one operation per latency+2 cycles; accept and complete SHALL never overlap.
REQ-022 NCHUNK=1 SHALL be legal: single BUSY cycle.
REQ-023 Elaboration SHALL fail if DATA_W%CHUNK_W!=0 or CHUNK_W<1.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, eq_out=gt_out=lt_out=0, out_valid=0, chunk index=0 and captured operands=0.
REQ-025 Reset SHALL abort any operation in BUSY or DONE with no result delivered.
REQ-026 After release, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-027 Macro MWCMP_SIGNED_EN defined SHALL add input port signed_mode (1 bit), captured at accept.
REQ-028 With signed_mode captured as 1, the MSB chunk SHALL be compared as two's complement and all lower chunks unsigned.
REQ-029 Without MWCMP_SIGNED_EN, signed_mode SHALL be absent and every chunk compared unsigned.

Structure
REQ-030 Package mwcmp_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and a 2-bit chunk-result enum (CH_EQ, CH_GT, CH_LT).
REQ-031 Sub-module mwcmp_chunk SHALL be a combinational CHUNK_W slice comparator with a signed-select input, returning the chunk-result enum; it SHALL be instantiated once.

Verification (DATA_W=32, CHUNK_W=4, NCHUNK=8)
REQ-032 a=b=0x12345678 with eq_in=1, gt_in=0, lt_in=0 -> out_valid 8 cycles after accept; eq/gt/lt=1/0/0.
REQ-033 a=0x80000000, b=0x7FFFFFFF unsigned -> gt_out=1 after 1 cycle; with MWCMP_SIGNED_EN and signed_mode=1 -> lt_out=1 after 1 cycle.
REQ-034 a=0x12345670, b=0x12345671 -> lt_out=1, eq_out=0 after 8 cycles; a=b with cascade gt_in=1, eq_in=0 -> gt_out=1 after 8 cycles.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0; pulse out_ready -> in_ready=1 next cycle.
REQ-036 Assert rst_n=0 asynchronously in the third BUSY cycle -> all outputs 0 immediately, IDLE; the next operation completes normally.
REQ-037 in_valid held 1 with out_ready tied 1 over 3 operand pairs -> 3 correct results, each accept exactly one cycle after the previous DONE handshake.

Source files
------------

// File: rtl/mwcmp_pkg.sv
// Shared types for the multi-word chunk-serial comparator.
// Holds the FSM state enum and the per-chunk compare result enum.
package mwcmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CH_EQ = 2'd0,
        CH_GT = 2'd1,
        CH_LT = 2'd2
    } chres_t;

endpackage

// File: rtl/mwcmp_chunk.sv
// Combinational W-bit slice comparator, signed or unsigned per signed_sel.
// Ports: a, b (slice operands), signed_sel (two's complement), res (chres_t).
import mwcmp_pkg::*;

module mwcmp_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_sel,
    output chres_t       res
);

    always_comb begin
        res = CH_EQ;
        if (a != b) begin
            if (signed_sel) begin
                res = ($signed(a) > $signed(b)) ? CH_GT : CH_LT;
            end else begin
                res = (a > b) ? CH_GT : CH_LT;
            end
        end
    end

endmodule

// File: rtl/multiword_comparator.sv
// Chunk-serial magnitude comparator, MSB chunk first, with early exit and
// cascade inputs. Ports: clk, rst_n, in_valid/in_ready, a, b,
// eq_in/gt_in/lt_in, out_valid/out_ready, eq_out/gt_out/lt_out.
// Define MWCMP_SIGNED_EN to add signed_mode (MSB chunk two's complement).
import mwcmp_pkg::*;

module multiword_comparator #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MWCMP_SIGNED_EN
    input  logic              signed_mode,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              eq_in,
    input  logic              gt_in,
    input  logic              lt_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              eq_out,
    output logic              gt_out,
    output logic              lt_out
);

    // CW guards the division so a bad CHUNK_W reaches the $error below.
    localparam int CW     = (CHUNK_W < 1) ? 1 : CHUNK_W;
    localparam int NCHUNK = DATA_W / CW;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

    generate
        if (CHUNK_W < 1 || (DATA_W % CW) != 0) begin : g_bad_cfg
            $error("DATA_W must be a positive multiple of CHUNK_W");
        end
    endgenerate

    state_t            state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              eq_c;
    logic              gt_c;
    logic              lt_c;
    logic [CW-1:0]     a_sl;
    logic [CW-1:0]     b_sl;
    logic              sel;
    chres_t            res;

    assign a_sl = CW'(a_q >> (int'(idx) * CW));
    assign b_sl = CW'(b_q >> (int'(idx) * CW));

`ifdef MWCMP_SIGNED_EN
    logic sgn_q;
    // Only the most significant chunk carries the sign.
    assign sel = sgn_q & (idx == TOP_IDX);
`else
    assign sel = 1'b0;
`endif

    mwcmp_chunk #(.W(CW)) u_chunk (
        .a          (a_sl),
        .b          (b_sl),
        .signed_sel (sel),
        .res        (res)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            eq_c   <= 1'b0;
            gt_c   <= 1'b0;
            lt_c   <= 1'b0;
            eq_out <= 1'b0;
            gt_out <= 1'b0;
            lt_out <= 1'b0;
`ifdef MWCMP_SIGNED_EN
            sgn_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        eq_c  <= eq_in;
                        gt_c  <= gt_in;
                        lt_c  <= lt_in;
                        idx   <= TOP_IDX;
                        state <= BUSY;
`ifdef MWCMP_SIGNED_EN
                        sgn_q <= signed_mode;
`endif
                    end
                end
                BUSY: begin
                    if (res == CH_GT || res == CH_LT) begin
                        eq_out <= 1'b0;
                        gt_out <= (res == CH_GT);
                        lt_out <= (res == CH_LT);
                        state  <= DONE;
                    end else if (idx == '0) begin
                        // Fully equal: pass the cascade through verbatim.
                        eq_out <= eq_c;
                        gt_out <= gt_c;
                        lt_out <= lt_c;
                        state  <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
